// File: rtl/bus_sequencer_arbiter.sv
// Round-robin arbiter sharing one bus_sequencer among NUM_REQ requesters; routes read bytes back.
// Latency: grant 1 cycle after an idle request; done 1 cycle after ready returns; read bytes 1 cycle.
// Backpressure: holds requests in IDLE while the sequencer is not ready; transactions end on ready or timeout.
module bus_sequencer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]               grant_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic [NUM_REQ-1:0]               timeout_o,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [7:0]                       rsp_data_o,
    output logic                             seq_start_o,
    output logic [ADDRESS_WIDTH-1:0]         seq_start_addr_o,
    input  logic                             seq_ready_i,
    input  logic                             seq_data_valid_i,
    input  logic [7:0]                       seq_data_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, FINISH} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         cur_idx;
    logic [IDX_W-1:0]         sel_idx;
    logic [IDX_W-1:0]         rr_cand;
    logic                     sel_found;
    logic [TMR_W-1:0]         timer;
    logic [TMR_W-1:0]         timer_inc;
    logic                     timed_out;
    logic                     in_txn;
    logic [ADDRESS_WIDTH-1:0] req_addr [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_addr
            assign req_addr[g] = req_addr_i[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
    endgenerate

    // Search starts just after the last served requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!sel_found && req_i[rr_cand]) begin
                sel_found = 1'b1;
                sel_idx   = rr_cand;
            end
        end
    end

    assign timer_inc = (timer == TMR_LIMIT) ? timer : timer + 1'b1;
    assign in_txn    = (state == START) || (state == WAIT_BUSY) || (state == WAIT_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is tested before the limit so a coincident return is not a timeout.
    always_comb begin
        state_nxt = state;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (seq_ready_i && sel_found) begin
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!seq_ready_i) begin
                    state_nxt = WAIT_DONE;
                end else if (timer_inc == TMR_LIMIT) begin
                    state_nxt = FINISH;
                    timed_out = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (seq_ready_i) begin
                    state_nxt = FINISH;
                end else if (timer_inc == TMR_LIMIT) begin
                    state_nxt = FINISH;
                    timed_out = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_o          <= '0;
            done_o           <= '0;
            timeout_o        <= '0;
            rsp_valid_o      <= '0;
            rsp_data_o       <= '0;
            seq_start_o      <= 1'b0;
            seq_start_addr_o <= '0;
            timer            <= '0;
            cur_idx          <= '0;
            last_grant       <= LAST_IDX;
        end else begin
            seq_start_o <= 1'b0;
            done_o      <= '0;
            timeout_o   <= '0;
            rsp_valid_o <= '0;
            case (state)
                IDLE: begin
                    if (state_nxt == START) begin
                        grant_o          <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        cur_idx          <= sel_idx;
                        seq_start_addr_o <= req_addr[sel_idx];
                        seq_start_o      <= 1'b1;
                    end
                end
                START:                timer <= '0;
                WAIT_BUSY, WAIT_DONE: timer <= timer_inc;
                FINISH: begin
                    last_grant <= cur_idx;
                    grant_o    <= '0;
                end
                default: ;
            endcase
            if (in_txn && (state_nxt == FINISH)) begin
                done_o <= grant_o;
                if (timed_out) begin
                    timeout_o <= grant_o;
                end
            end
            if (in_txn && seq_data_valid_i) begin
                rsp_valid_o <= grant_o;
                rsp_data_o  <= seq_data_i;
            end
        end
    end

endmodule
